// File: rtl/pwm_duty_ctrl_if.sv
// -----------------------------------------------------------------------------
// pwm_duty_ctrl_if
//   Connection bundle between the PS/2 front end, the duty controller and the
//   PWM generator.
//
//   Signals:
//     code_valid   one-cycle strobe, code carries a new scancode byte
//     code[7:0]    scancode byte from the PS/2 receiver
//     period_tick  one-cycle pulse at PWM counter wrap
//     duty         live duty handed to the PWM generator
//     target       duty the controller is ramping toward
//     busy         duty has not yet reached target
//     key_held     a mapped key is currently held down
//
//   Modports:
//     master  drives code_valid/code/period_tick, observes the duty outputs
//     slave   the controller side
// -----------------------------------------------------------------------------
interface pwm_duty_ctrl_if #(
   parameter int DUTY_W = 7
);
   logic              code_valid;
   logic [7:0]        code;
   logic              period_tick;
   logic [DUTY_W-1:0] duty;
   logic [DUTY_W-1:0] target;
   logic              busy;
   logic              key_held;

   modport master (
      output code_valid,
      output code,
      output period_tick,
      input  duty,
      input  target,
      input  busy,
      input  key_held
   );

   modport slave (
      input  code_valid,
      input  code,
      input  period_tick,
      output duty,
      output target,
      output busy,
      output key_held
   );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_duty_ctrl
//   Turns PS/2 scancodes into a PWM duty setting. A small decoder tracks the
//   F0 (break) and E0 (extended) prefixes; mapped make codes select a target
//   duty, releasing the held key restores the default, and the extended
//   up/down arrows nudge the target with saturation. The live duty then walks
//   toward the target by STEP once every RAMP_DIV PWM periods, so the PWM
//   generator only ever sees a change at a period boundary.
//
//   Ports:
//     clk     system clock
//     reset   asynchronous reset, active low
//     bus     pwm_duty_ctrl_if slave modport
//               in : code_valid, code[7:0], period_tick
//               out: duty, target, busy, key_held
// -----------------------------------------------------------------------------
module pwm_duty_ctrl #(
   parameter int DUTY_W       = 7,
   parameter int DEFAULT_DUTY = 80,
   parameter int DUTY_MAX     = 100,
   parameter int STEP         = 1,
   parameter int ADJ_STEP     = 5,
   parameter int RAMP_DIV     = 1
) (
   input  logic           clk,
   input  logic           reset,
   pwm_duty_ctrl_if.slave bus
);

   // ---------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------
   localparam logic [7:0] CODE_BRK  = 8'hF0;
   localparam logic [7:0] CODE_EXT  = 8'hE0;
   localparam logic [7:0] CODE_UP   = 8'h75;
   localparam logic [7:0] CODE_DOWN = 8'h72;

   localparam int         N_KEYS = 4;
   localparam logic [7:0] KEY_CODE [N_KEYS] = '{8'h2B, 8'h15, 8'h33, 8'h22};
   localparam int         KEY_DUTY [N_KEYS] = '{20, 25, 30, 80};

   localparam logic [DUTY_W-1:0] DEFAULT_V = DUTY_W'(DEFAULT_DUTY);
   localparam logic [DUTY_W-1:0] STEP_V    = DUTY_W'(STEP);
   // One extra bit so target+ADJ_STEP cannot wrap before it is clamped.
   localparam logic [DUTY_W:0]   MAX_WIDE  = (DUTY_W+1)'(DUTY_MAX);
   localparam logic [DUTY_W:0]   ADJ_WIDE  = (DUTY_W+1)'(ADJ_STEP);

   localparam int             CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BRK     = 2'd1,
      S_EXT     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t            state_reg;
   logic [DUTY_W-1:0] target_reg;
   logic [7:0]        held_code_reg;
   logic              key_held_reg;
   logic [DUTY_W-1:0] duty_reg;
   logic [CNT_W-1:0]  ramp_cnt_reg;

   // ---------------------------------------------------------------------
   // Make-code lookup: one comparator per mapped key
   // ---------------------------------------------------------------------
   logic [N_KEYS-1:0] key_hit;
   logic [DUTY_W-1:0] key_duty_table [N_KEYS];
   logic              key_mapped;
   logic [DUTY_W-1:0] key_duty;

   generate
      for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
         assign key_hit[gi]        = (bus.code == KEY_CODE[gi]);
         assign key_duty_table[gi] = DUTY_W'(KEY_DUTY[gi]);
      end
   endgenerate

   // Codes in the table are distinct, so at most one hit bit is set.
   always_comb begin
      key_mapped = |key_hit;
      key_duty   = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (key_hit[i]) begin
            key_duty = key_duty_table[i];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Arrow-key adjust with saturation at DUTY_MAX and at zero
   // ---------------------------------------------------------------------
   logic [DUTY_W:0]   up_sum;
   logic [DUTY_W-1:0] up_target;
   logic [DUTY_W-1:0] down_target;

   always_comb begin
      up_sum      = {1'b0, target_reg} + ADJ_WIDE;
      up_target   = (up_sum > MAX_WIDE) ? MAX_WIDE[DUTY_W-1:0] : up_sum[DUTY_W-1:0];
      down_target = ({1'b0, target_reg} >= ADJ_WIDE) ?
                    (target_reg - ADJ_WIDE[DUTY_W-1:0]) : '0;
   end

   // ---------------------------------------------------------------------
   // Scancode decoder FSM. Only code_valid cycles advance it.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         target_reg    <= DEFAULT_V;
         held_code_reg <= '0;
         key_held_reg  <= 1'b0;
      end else if (bus.code_valid) begin
         case (state_reg)
            S_IDLE: begin
               if (bus.code == CODE_BRK) begin
                  state_reg <= S_BRK;
               end else if (bus.code == CODE_EXT) begin
                  state_reg <= S_EXT;
               end else if (key_mapped) begin
                  // A newer make simply takes over; the earlier key's
                  // break will no longer match held_code_reg.
                  target_reg    <= key_duty;
                  held_code_reg <= bus.code;
                  key_held_reg  <= 1'b1;
               end
            end
            S_BRK: begin
               state_reg <= S_IDLE;
               if (bus.code == held_code_reg) begin
                  target_reg   <= DEFAULT_V;
                  key_held_reg <= 1'b0;
               end
            end
            S_EXT: begin
               if (bus.code == CODE_BRK) begin
                  state_reg <= S_EXT_BRK;
               end else begin
                  state_reg <= S_IDLE;
                  if (bus.code == CODE_UP) begin
                     target_reg <= up_target;
                  end else if (bus.code == CODE_DOWN) begin
                     target_reg <= down_target;
                  end
               end
            end
            S_EXT_BRK: begin
               // Extended releases carry no meaning here.
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Duty ramp. target_reg is read before any same-cycle decoder update,
   // so a coincident code_valid only affects the following ramp event.
   // ---------------------------------------------------------------------
   logic [DUTY_W-1:0] duty_next;
   logic              ramp_event;

   always_comb begin
      duty_next = duty_reg;
      if (target_reg > duty_reg) begin
         duty_next = ((target_reg - duty_reg) >= STEP_V) ? (duty_reg + STEP_V) : target_reg;
      end else if (target_reg < duty_reg) begin
         duty_next = ((duty_reg - target_reg) >= STEP_V) ? (duty_reg - STEP_V) : target_reg;
      end
   end

   assign ramp_event = bus.period_tick && (ramp_cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         duty_reg     <= DEFAULT_V;
         ramp_cnt_reg <= '0;
      end else if (bus.period_tick) begin
         if (ramp_event) begin
            ramp_cnt_reg <= '0;
            duty_reg     <= duty_next;
         end else begin
            ramp_cnt_reg <= ramp_cnt_reg + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.duty     = duty_reg;
   assign bus.target   = target_reg;
   assign bus.busy     = (duty_reg != target_reg);
   assign bus.key_held = key_held_reg;

endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
- Controller that sequences the duty setting of the PWM generator from PS/2 keyboard scancodes.
- Decodes make, break and extended (E0) sequences from the PS/2 receiver and selects a target duty per key.
- Ramps the live duty toward the target one step per PWM period, so the generator never sees a mid-period jump.
- Sits between the PS/2 receiver (code strobe) and the PWM generator (duty input, period-wrap tick).

Parameters:
- DUTY_W, 7, width of duty/target values.
- DEFAULT_DUTY, 80, duty when no mapped key is held, and at reset.
- DUTY_MAX, 100, saturation ceiling for manual adjust.
- STEP, 1, duty change per ramp event.
- ADJ_STEP, 5, target change per arrow-key press.
- RAMP_DIV, 1, number of PWM periods per ramp event (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- code_valid  in  1  one-cycle strobe: code holds a new scancode byte.
- code  in  8  scancode byte from PS/2 receiver.
- period_tick  in  1  one-cycle pulse at PWM counter wrap.
- duty  out  DUTY_W  live duty to PWM generator.
- target  out  DUTY_W  current target duty.
- busy  out  1  high while duty != target.
- key_held  out  1  high while a mapped key is held.

Behaviour:
- Reset (reset=0, async): duty=DEFAULT_DUTY, target=DEFAULT_DUTY, busy=0, key_held=0, decoder state IDLE, held code=0, ramp counter=0.
- Decoder FSM advances only on code_valid cycles:
  - IDLE: F0 -> BRK; E0 -> EXT; mapped make code -> set target, latch held code, key_held=1, stay IDLE; any other byte -> no change.
  - BRK: any byte -> IDLE. If the byte equals the held code: target=DEFAULT_DUTY, key_held=0. Otherwise no change.
  - EXT: F0 -> EXT_BRK; 75 (up) -> target=min(target+ADJ_STEP, DUTY_MAX), IDLE; 72 (down) -> target=max(target-ADJ_STEP, 0), IDLE; other -> IDLE, no change.
  - EXT_BRK: any byte -> IDLE, no change (extended releases ignored).
- Make-code map: 2B->20, 15->25, 33->30, 22->80.
- A new make while another key is held replaces the target and the held code. The earlier key's later break is then ignored.
- Target update latency: registered on the code_valid cycle; visible on target the next cycle.
- Arrow adjust arithmetic uses DUTY_W+1 bits internally to saturate; no wrap.
- Ramp: on each period_tick the ramp counter increments. When it reaches RAMP_DIV-1 it clears and a ramp event occurs.
  - On a ramp event with |target-duty| >= STEP, duty moves STEP toward target.
  - On a ramp event with 0 < |target-duty| < STEP, duty=target.
  - duty changes only on ramp events, never otherwise.
- Simultaneous code_valid and period_tick: the ramp event uses the target registered before that cycle. The new target takes effect from the next ramp event.
- busy is combinational: busy = (duty != target).
- Mid-sequence reset (e.g. while in BRK) returns the FSM to IDLE; the pending byte is discarded.
- code_valid is ignored while reset=0.

Test Plan:
- Reset with defaults, then code 2B -> target=20 next cycle, key_held=1, busy=1. After 60 period_ticks duty=20 (decrements one per tick), busy=0.
- Send 2B, then F0 2B -> target returns to 80, key_held=0. Duty ramps back up by 1 per tick until it reaches 80.
- Send 15, then 33, then F0 15 -> target stays 30, key_held=1. F0 33 -> target=80.
- Set target to 80, then E0 75 five times -> target=100, sixth press stays 100. E0 F0 75 -> no change. Press E0 72 twenty-one times -> target saturates at 0.
- RAMP_DIV=4, target change 80->78 -> duty changes only on every 4th period_tick. code_valid coincident with the 4th tick -> ramp uses the old target.
- Assert reset while FSM is in BRK after F0, release, then send 2B -> treated as a make code: target=20, duty=80, ramp counter=0.
